// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the core pipeline, the data-memory port and dmem_arbiter.
// Signals:
//   IF side   : if_req_valid/ready, if_addr, if_resp_valid, if_rdata, if_resp_err
//   LSU side  : lsu_req_valid/ready, lsu_addr, lsu_wen, lsu_memop, lsu_wdata,
//               lsu_resp_valid, lsu_rdata, lsu_resp_err
//   Memory    : mem_req_valid/ready, mem_addr, mem_wen, mem_wdata, mem_wmask,
//               mem_resp_valid, mem_rdata
//   Status    : fatal_err
// Modports: slave = the arbiter, master = its environment (requesters + memory).
interface dmem_arbiter_if;
   localparam int unsigned AW = 64;
   localparam int unsigned DW = 64;
   localparam int unsigned IW = 32;
   localparam int unsigned MW = 8;

   logic          if_req_valid;
   logic          if_req_ready;
   logic [AW-1:0] if_addr;
   logic          if_resp_valid;
   logic [IW-1:0] if_rdata;
   logic          if_resp_err;

   logic          lsu_req_valid;
   logic          lsu_req_ready;
   logic [AW-1:0] lsu_addr;
   logic          lsu_wen;
   logic [2:0]    lsu_memop;
   logic [DW-1:0] lsu_wdata;
   logic          lsu_resp_valid;
   logic [DW-1:0] lsu_rdata;
   logic          lsu_resp_err;

   logic          mem_req_valid;
   logic          mem_req_ready;
   logic [AW-1:0] mem_addr;
   logic          mem_wen;
   logic [DW-1:0] mem_wdata;
   logic [MW-1:0] mem_wmask;
   logic          mem_resp_valid;
   logic [DW-1:0] mem_rdata;

   logic          fatal_err;

   modport slave (
      input  if_req_valid, if_addr,
      input  lsu_req_valid, lsu_addr, lsu_wen, lsu_memop, lsu_wdata,
      input  mem_req_ready, mem_resp_valid, mem_rdata,
      output if_req_ready, if_resp_valid, if_rdata, if_resp_err,
      output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
      output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
      output fatal_err
   );

   modport master (
      output if_req_valid, if_addr,
      output lsu_req_valid, lsu_addr, lsu_wen, lsu_memop, lsu_wdata,
      output mem_req_ready, mem_resp_valid, mem_rdata,
      input  if_req_ready, if_resp_valid, if_rdata, if_resp_err,
      input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
      input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
      input  fatal_err
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single 64-bit data-memory port between instruction fetch
// (read-only, 32-bit) and the load/store unit. One transaction in flight at a
// time; sub-word accesses are aligned/masked on the way out and shifted and
// extended on the way back.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - dmem_arbiter_if.slave: IF/LSU request-response and memory port
// Parameters:
//   TIMEOUT_CYCLES - cycles allowed in WAIT before the sticky fatal error
//   RR_RESET_LSU   - 1 = LSU wins the first tie after reset
module dmem_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter bit          RR_RESET_LSU   = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   dmem_arbiter_if.slave bus
);
   localparam int unsigned AW = 64;
   localparam int unsigned DW = 64;
   localparam int unsigned IW = 32;
   localparam int unsigned MW = 8;
   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_RESP,
      S_ERR
   } state_t;

   state_t        r_state;
   logic          r_prio_lsu;     // 1 = LSU wins the next tie
   logic          r_owner_lsu;    // owner of the current transaction
   logic          r_wen;
   logic [2:0]    r_memop;
   logic [2:0]    r_off;          // byte offset within the 8-byte line
   logic [CW-1:0] r_cnt;

   logic          r_mem_req_valid;
   logic [AW-1:0] r_mem_addr;
   logic          r_mem_wen;
   logic [DW-1:0] r_mem_wdata;
   logic [MW-1:0] r_mem_wmask;
   logic          r_if_resp_valid;
   logic [IW-1:0] r_if_rdata;
   logic          r_if_resp_err;
   logic          r_lsu_resp_valid;
   logic [DW-1:0] r_lsu_rdata;
   logic          r_lsu_resp_err;
   logic          r_fatal_err;

   logic          w_idle;
   logic          w_gnt_lsu;
   logic          w_gnt_if;
   logic          w_accept;
   logic [AW-1:0] w_sel_addr;
   logic          w_sel_wen;
   logic [2:0]    w_sel_memop;
   logic [DW-1:0] w_sel_wdata;
   logic [2:0]    w_off;
   logic          w_misaligned;
   logic [MW-1:0] w_bmask;
   logic [MW-1:0] w_wmask;
   logic [DW-1:0] w_wdata;
   logic [DW-1:0] w_rshift;
   logic [DW-1:0] w_ld;
   logic [IW-1:0] w_if_word;

   // Arbitration: a lone requester wins; on a tie the pointer decides.
   assign w_idle    = (r_state == S_IDLE);
   assign w_gnt_lsu = bus.lsu_req_valid & (~bus.if_req_valid | r_prio_lsu);
   assign w_gnt_if  = bus.if_req_valid & ~w_gnt_lsu;
   assign w_accept  = w_idle & (w_gnt_lsu | w_gnt_if);

   assign bus.lsu_req_ready = w_idle & w_gnt_lsu;
   assign bus.if_req_ready  = w_idle & w_gnt_if;

   // Selected request, alignment check and store-lane formatting.
   always_comb begin
      w_sel_addr   = bus.if_addr;
      w_sel_wen    = 1'b0;
      w_sel_memop  = 3'b010;        // fetch is always a 32-bit read
      w_sel_wdata  = '0;
      w_misaligned = 1'b0;
      w_bmask      = 8'h00;
      if (w_gnt_lsu) begin
         w_sel_addr  = bus.lsu_addr;
         w_sel_wen   = bus.lsu_wen;
         w_sel_memop = bus.lsu_memop;
         w_sel_wdata = bus.lsu_wdata;
      end
      w_off = w_sel_addr[2:0];
      case (w_sel_memop[1:0])
         2'd0: begin
            w_misaligned = 1'b0;
            w_bmask      = 8'h01;
         end
         2'd1: begin
            w_misaligned = w_off[0];
            w_bmask      = 8'h03;
         end
         2'd2: begin
            w_misaligned = (w_off[1:0] != 2'd0);
            w_bmask      = 8'h0F;
         end
         default: begin
            w_misaligned = (w_off != 3'd0);
            w_bmask      = 8'hFF;
         end
      endcase
      w_wmask = w_sel_wen ? (w_bmask << w_off) : '0;
      w_wdata = w_sel_wen ? (w_sel_wdata << {w_off, 3'b000}) : '0;
   end

   // Load-data return path: shift the lane down, then truncate and extend.
   always_comb begin
      w_rshift  = bus.mem_rdata >> {r_off, 3'b000};
      w_if_word = r_off[2] ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
      case (r_memop[1:0])
         2'd0: w_ld = r_memop[2] ? {{(DW-8){1'b0}}, w_rshift[7:0]}
                                 : {{(DW-8){w_rshift[7]}}, w_rshift[7:0]};
         2'd1: w_ld = r_memop[2] ? {{(DW-16){1'b0}}, w_rshift[15:0]}
                                 : {{(DW-16){w_rshift[15]}}, w_rshift[15:0]};
         2'd2: w_ld = r_memop[2] ? {{(DW-32){1'b0}}, w_rshift[31:0]}
                                 : {{(DW-32){w_rshift[31]}}, w_rshift[31:0]};
         default: w_ld = w_rshift;
      endcase
   end

   // Sequencer with registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state          <= S_IDLE;
         r_prio_lsu       <= RR_RESET_LSU;
         r_owner_lsu      <= 1'b0;
         r_wen            <= 1'b0;
         r_memop          <= 3'b000;
         r_off            <= 3'b000;
         r_cnt            <= '0;
         r_mem_req_valid  <= 1'b0;
         r_mem_addr       <= '0;
         r_mem_wen        <= 1'b0;
         r_mem_wdata      <= '0;
         r_mem_wmask      <= '0;
         r_if_resp_valid  <= 1'b0;
         r_if_rdata       <= '0;
         r_if_resp_err    <= 1'b0;
         r_lsu_resp_valid <= 1'b0;
         r_lsu_rdata      <= '0;
         r_lsu_resp_err   <= 1'b0;
         r_fatal_err      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_owner_lsu <= w_gnt_lsu;
                  r_prio_lsu  <= ~w_gnt_lsu;
                  r_wen       <= w_sel_wen;
                  r_memop     <= w_sel_memop;
                  r_off       <= w_off;
                  if (w_misaligned) begin
                     // Reject without touching memory.
                     r_state <= S_RESP;
                     if (w_gnt_lsu) begin
                        r_lsu_resp_valid <= 1'b1;
                        r_lsu_rdata      <= '0;
                        r_lsu_resp_err   <= 1'b1;
                     end else begin
                        r_if_resp_valid <= 1'b1;
                        r_if_rdata      <= '0;
                        r_if_resp_err   <= 1'b1;
                     end
                  end else begin
                     r_state         <= S_REQ;
                     r_mem_req_valid <= 1'b1;
                     r_mem_addr      <= {w_sel_addr[AW-1:3], 3'b000};
                     r_mem_wen       <= w_sel_wen;
                     r_mem_wdata     <= w_wdata;
                     r_mem_wmask     <= w_wmask;
                  end
               end
            end
            S_REQ: begin
               if (bus.mem_req_ready) begin
                  r_mem_req_valid <= 1'b0;
                  r_cnt           <= '0;
                  r_state         <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (bus.mem_resp_valid) begin
                  r_state <= S_RESP;
                  if (r_owner_lsu) begin
                     r_lsu_resp_valid <= 1'b1;
                     r_lsu_rdata      <= r_wen ? '0 : w_ld;
                     r_lsu_resp_err   <= 1'b0;
                  end else begin
                     r_if_resp_valid <= 1'b1;
                     r_if_rdata      <= w_if_word;
                     r_if_resp_err   <= 1'b0;
                  end
               end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                  // This is the TIMEOUT_CYCLES-th silent cycle: give up.
                  r_cnt       <= r_cnt + CW'(1);
                  r_state     <= S_ERR;
                  r_fatal_err <= 1'b1;
                  if (r_owner_lsu) begin
                     r_lsu_resp_valid <= 1'b1;
                     r_lsu_rdata      <= '0;
                     r_lsu_resp_err   <= 1'b1;
                  end else begin
                     r_if_resp_valid <= 1'b1;
                     r_if_rdata      <= '0;
                     r_if_resp_err   <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_RESP: begin
               r_if_resp_valid  <= 1'b0;
               r_lsu_resp_valid <= 1'b0;
               r_state          <= S_IDLE;
            end
            S_ERR: begin
               // Terminal until reset; the error response was a single pulse.
               r_if_resp_valid  <= 1'b0;
               r_lsu_resp_valid <= 1'b0;
               r_mem_req_valid  <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.mem_req_valid  = r_mem_req_valid;
   assign bus.mem_addr       = r_mem_addr;
   assign bus.mem_wen        = r_mem_wen;
   assign bus.mem_wdata      = r_mem_wdata;
   assign bus.mem_wmask      = r_mem_wmask;
   assign bus.if_resp_valid  = r_if_resp_valid;
   assign bus.if_rdata       = r_if_rdata;
   assign bus.if_resp_err    = r_if_resp_err;
   assign bus.lsu_resp_valid = r_lsu_resp_valid;
   assign bus.lsu_rdata      = r_lsu_rdata;
   assign bus.lsu_resp_err   = r_lsu_resp_err;
   assign bus.fatal_err      = r_fatal_err;
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter and sequencer that shares the single 64-bit data-memory port between instruction fetch (IF, read-only) and the load/store unit (LSU). It accepts one request at a time and runs a request/response handshake on the memory side, with one transaction outstanding at most. It also formats sub-word accesses: 8-byte-aligned address, byte write mask, lane-shifted write data, and aligned, sign- or zero-extended read data. It sits between the core pipeline and the memory interface (DPI pmem model in simulation).

Parameters:
TIMEOUT_CYCLES, 256, max cycles in WAIT before fatal timeout; counter width clog2(TIMEOUT_CYCLES+1)
RR_RESET_LSU, 1, 1 = LSU wins the first tie after reset

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req_valid  in  1  IF read request
if_req_ready  out  1  IF request accepted this cycle
if_addr  in  64  instruction address; bits [1:0] must be 0
if_resp_valid  out  1  one-cycle response pulse to IF
if_rdata  out  32  instruction word, selected by addr[2]
if_resp_err  out  1  misaligned or fault, qualified by if_resp_valid
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_addr  in  64  byte address
lsu_wen  in  1  1 = store
lsu_memop  in  3  [1:0] size (0 = B, 1 = H, 2 = W, 3 = D); [2] = 1 zero-extends a load
lsu_wdata  in  64  store data, LSB-justified
lsu_resp_valid  out  1  one-cycle response pulse to LSU
lsu_rdata  out  64  extended load data; 0 for stores and errors
lsu_resp_err  out  1  misaligned or fault
mem_req_valid  out  1  memory request
mem_req_ready  in  1  memory accepts request
mem_addr  out  64  addr & ~7
mem_wen  out  1  write enable
mem_wdata  out  64  lane-shifted write data
mem_wmask  out  8  byte mask; 0 for reads
mem_resp_valid  in  1  memory response (reads and write acks)
mem_rdata  in  64  raw 8-byte line
fatal_err  out  1  sticky timeout flag

Behaviour:
- States: IDLE, REQ, WAIT, RESP, ERR. Reset value is IDLE. All outputs reset to 0, and the round-robin pointer resets per RR_RESET_LSU.
- Requesters cannot back-pressure responses; resp_valid is a single-cycle pulse.
- IDLE arbitration:
  - Only one valid request: that requester is granted.
  - Both valid: the requester not granted last time wins, and the pointer flips on every grant.
  - The ready signal is combinational: high only in IDLE and only for the grantee.
  - On the handshake, addr, wen, memop and wdata are latched; IF requests latch as a 32-bit read.
- Alignment check at accept:
  - Aligned means addr mod (1 << size) == 0.
  - Misaligned requests go directly to RESP with err = 1, rdata = 0, and no memory access.
  - Aligned requests go to REQ.
- REQ: mem_req_valid = 1 with stable fields until mem_req_ready is high at a rising edge, then go to WAIT and clear the timeout counter.
- Write formatting: mem_wmask = ((1 << (1 << size)) - 1) << addr[2:0]; mem_wdata = wdata << (8 * addr[2:0]).
- WAIT:
  - mem_resp_valid: latch formatted data and go to RESP.
  - Read data = mem_rdata >> (8 * addr[2:0]), truncated to the access size, then sign-extended unless memop[2] = 1.
  - IF data = addr[2] ? mem_rdata[63:32] : mem_rdata[31:0].
  - Otherwise the counter increments; when it reaches TIMEOUT_CYCLES, go to ERR.
- RESP: assert the owner's resp_valid for exactly one cycle, then go to IDLE. A new request can be accepted in the following cycle.
- Minimum latency: accept at cycle N, mem_req_valid at N+1, response at N+2 (if memory answers the cycle after acceptance), resp_valid at N+3.
- ERR:
  - fatal_err = 1; both ready signals = 0; mem_req_valid = 0; the owner gets resp_valid with err = 1 once on entry.
  - Only reset leaves ERR.
- mem_resp_valid outside WAIT is ignored.
- Reset mid-transaction: state returns to IDLE immediately and asynchronously, with no response issued.
- The non-granted requester holds its valid; the block never drops a request that was not accepted.

Test Plan:
- LSU load, lsu_addr = 0x80000006, memop = 3'b001 (signed H), mem_rdata = 0xABCD_0000_0000_0000 -> mem_addr = 0x80000000, mem_wmask = 0, lsu_rdata = 0xFFFF_FFFF_FFFF_ABCD, response 3 cycles after accept with 1-cycle memory.
- LSU store, addr = 0x80000003, memop = 3'b000, wdata = 0x5A -> mem_wmask = 8'b0000_1000, mem_wdata = 0x5A000000, mem_wen = 1; lsu_resp_valid = 1 with lsu_rdata = 0.
- IF and LSU both valid every cycle for 4 transactions from reset -> grant order LSU, IF, LSU, IF; never both ready in the same cycle.
- LSU word load at 0x80000002 -> lsu_resp_err = 1 one cycle after accept; mem_req_valid never asserted.
- mem_req_ready held low for 5 cycles -> mem_req_valid and all mem_* fields stable throughout; completes normally afterwards.
- TIMEOUT_CYCLES = 8 and no mem_resp_valid -> fatal_err rises after 8 WAIT cycles; owner gets err = 1; readies stay 0 until rst_n pulses low, after which everything returns to reset values.
